// File: rtl/led_blink_controller.sv
// LED blink controller: command-driven LED sequencer with OFF, ON, free-running
// BLINK and counted BURST modes. BURST runs to completion and then pulses done.
module led_blink_controller #(
    parameter longint unsigned CLK_DIV = 64'd50_000_000,
    parameter int unsigned     CNT_W   = 32'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             led,
    output logic             busy,
    output logic             done
);

    // Half-period counter width and its terminal value.
    localparam int unsigned       DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 64'd1);
    localparam logic [DIV_W-1:0]  DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    // Command encodings as seen on cmd_mode.
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STEADY = 2'b01,
        ST_BLINK  = 2'b10,
        ST_BURST  = 2'b11
    } state_t;

    state_t             state_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [CNT_W-1:0]   remaining_r;
    logic               led_r;
    logic               done_r;

    logic               accept_s;
    logic               counting_s;
    logic               tick_s;

    // Handshake, activity decode and half-period tick detection.
    always_comb begin
        counting_s = (state_r == ST_BLINK) || (state_r == ST_BURST);
        cmd_ready  = (state_r != ST_BURST);
        busy       = counting_s;
        accept_s   = cmd_valid && cmd_ready;
        tick_s     = counting_s && (div_cnt_r == DIV_MAX);
    end

    // Main FSM: command acceptance, half-period counting, LED toggling and burst bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            div_cnt_r   <= '0;
            remaining_r <= '0;
            led_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                // A new command always restarts timing from zero, even for the same mode.
                div_cnt_r <= '0;
                case (cmd_mode)
                    MODE_OFF: begin
                        state_r     <= ST_IDLE;
                        led_r       <= 1'b0;
                        remaining_r <= '0;
                    end
                    MODE_ON: begin
                        state_r     <= ST_STEADY;
                        led_r       <= 1'b1;
                        remaining_r <= '0;
                    end
                    MODE_BLINK: begin
                        state_r     <= ST_BLINK;
                        led_r       <= 1'b1;
                        remaining_r <= '0;
                    end
                    MODE_BURST: begin
                        if (cmd_count != '0) begin
                            state_r     <= ST_BURST;
                            led_r       <= 1'b1;
                            remaining_r <= cmd_count;
                        end else begin
                            // Empty burst completes immediately: done is visible the next cycle.
                            state_r     <= ST_IDLE;
                            led_r       <= 1'b0;
                            remaining_r <= '0;
                            done_r      <= 1'b1;
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        led_r       <= 1'b0;
                        remaining_r <= '0;
                    end
                endcase
            end else if (counting_s) begin
                if (tick_s) begin
                    div_cnt_r <= '0;
                    if (state_r == ST_BURST) begin
                        if (led_r) begin
                            // End of an on half-period: one blink consumed.
                            led_r       <= 1'b0;
                            remaining_r <= remaining_r - CNT_ONE;
                        end else if (remaining_r == '0) begin
                            // Final off half-period finished: burst complete.
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            led_r <= 1'b1;
                        end
                    end else begin
                        led_r <= ~led_r;
                    end
                end else begin
                    div_cnt_r <= div_cnt_r + DIV_ONE;
                end
            end else begin
                // IDLE and STEADY: counter parked at zero, LED held.
                div_cnt_r <= '0;
            end
        end
    end

    assign led  = led_r;
    assign done = done_r;

endmodule

// File: tb/tb_led_blink_controller.sv
// Directed bench for led_blink_controller with CLK_DIV=4, CNT_W=8.
// Expected output vectors are queued as each command is driven and compared
// one entry per cycle at the falling clock edge.
module tb_led_blink_controller;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_count;
    logic       led;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    typedef struct packed {
        logic led;
        logic busy;
        logic ready;
        logic done;
    } exp_t;

    exp_t exp_q[$];

    led_blink_controller #(
        .CLK_DIV (64'd4),
        .CNT_W   (32'd8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic l, input logic b, input logic r, input logic d);
        exp_t e;
        e.led   = l;
        e.busy  = b;
        e.ready = r;
        e.done  = d;
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: scoreboard empty, observed led=%b busy=%b ready=%b done=%b", tag, led, busy, cmd_ready, done);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (led === e.led) else begin
                failures++;
                $error("FAIL %s.led observed=%b expected=%b", tag, led, e.led);
            end
            checks++;
            assert (busy === e.busy) else begin
                failures++;
                $error("FAIL %s.busy observed=%b expected=%b", tag, busy, e.busy);
            end
            checks++;
            assert (cmd_ready === e.ready) else begin
                failures++;
                $error("FAIL %s.ready observed=%b expected=%b", tag, cmd_ready, e.ready);
            end
            checks++;
            assert (done === e.done) else begin
                failures++;
                $error("FAIL %s.done observed=%b expected=%b", tag, done, e.done);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'b00;
        cmd_count = 8'd0;

        // Reset asserted between edges: outputs settle without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 1'b0, 1'b1, 1'b0);
        check_pop("reset_async");

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 20 cycles after reset.
        for (int k = 0; k < 20; k++) begin
            push_exp(1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check_pop($sformatf("idle_k%0d", k));
        end

        // BLINK: led high on the accept edge, toggling every 4 cycles.
        cmd_valid = 1'b1;
        cmd_mode  = 2'b10;
        cmd_count = 8'd0;
        for (int k = 0; k < 14; k++) begin
            push_exp(((k / 4) % 2) == 0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            check_pop($sformatf("blink_k%0d", k));
            if (k == 0) cmd_valid = 1'b0;
        end

        // ON during BLINK: led steady high from the accept edge.
        cmd_valid = 1'b1;
        cmd_mode  = 2'b01;
        for (int k = 0; k < 10; k++) begin
            push_exp(1'b1, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check_pop($sformatf("on_k%0d", k));
            if (k == 0) cmd_valid = 1'b0;
        end

        // BURST of 3: three 4-cycle high pulses, done at T+24; a pending ON is held off until then.
        cmd_valid = 1'b1;
        cmd_mode  = 2'b11;
        cmd_count = 8'd3;
        for (int k = 0; k < 26; k++) begin
            if (k < 24)       push_exp(((k / 4) % 2) == 0, 1'b1, 1'b0, 1'b0);
            else if (k == 24) push_exp(1'b0, 1'b0, 1'b1, 1'b1);
            else              push_exp(1'b1, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check_pop($sformatf("burst3_k%0d", k));
            if (k == 0) cmd_valid = 1'b0;
            if (k == 5) begin
                cmd_valid = 1'b1;
                cmd_mode  = 2'b01;
                cmd_count = 8'd0;
            end
            if (k == 25) cmd_valid = 1'b0;
        end

        // BURST of 0 from STEADY: led off, done pulse right after accept, nothing afterwards.
        cmd_valid = 1'b1;
        cmd_mode  = 2'b11;
        cmd_count = 8'd0;
        for (int k = 0; k < 8; k++) begin
            push_exp(1'b0, 1'b0, 1'b1, (k == 0));
            @(negedge clk);
            check_pop($sformatf("burst0_k%0d", k));
            if (k == 0) cmd_valid = 1'b0;
        end

        // BLINK restarted by a second BLINK command mid half-period.
        cmd_valid = 1'b1;
        cmd_mode  = 2'b10;
        for (int k = 0; k < 6; k++) begin
            push_exp(((k / 4) % 2) == 0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            check_pop($sformatf("blinkA_k%0d", k));
            if (k == 0) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            push_exp(((k / 4) % 2) == 0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            check_pop($sformatf("blinkB_k%0d", k));
            if (k == 0) cmd_valid = 1'b0;
        end

        // BURST of 2 aborted by reset between clock edges.
        cmd_valid = 1'b1;
        cmd_mode  = 2'b11;
        cmd_count = 8'd2;
        for (int k = 0; k < 10; k++) begin
            push_exp(((k / 4) % 2) == 0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            check_pop($sformatf("burst2_k%0d", k));
            if (k == 0) cmd_valid = 1'b0;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 1'b0, 1'b1, 1'b0);
        check_pop("abort_async");
        for (int k = 0; k < 12; k++) begin
            push_exp(1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check_pop($sformatf("abort_k%0d", k));
            if (k == 0) rst_n = 1'b1;
        end

        // Command presented as reset releases is accepted on the first edge.
        rst_n = 1'b0;
        push_exp(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_pop("rel_hold");
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = 2'b01;
        push_exp(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_pop("rel_first_cmd");
        cmd_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
